// File: rtl/s2f_counter.sv
// Slow-rate counter whose value is Gray-coded and passed through a flop chain
// to a fast-domain copy; everything runs on the single clock clk2.
module s2f_counter_core #(
  parameter int WIDTH       = 4,
  parameter int RATIO       = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk2,
  input  logic             reset,
  output logic [WIDTH-1:0] count_1,
  output logic [WIDTH-1:0] count_2
);

  localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATIO - 1);

  logic [PH_W-1:0]  ph;
  logic             tk;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] gray_next;
  logic [WIDTH-1:0] bin_dec;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  assign tk        = (ph == PH_LAST);
  assign gray_next = count_1 ^ (count_1 >> 1);

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      ph <= '0;
    end else if (tk) begin
      ph <= '0;
    end else begin
      ph <= ph + PH_W'(1);
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      count_1 <= '0;
    end else if (tk) begin
      count_1 <= count_1 + WIDTH'(1);
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      g1 <= '0;
    end else begin
      g1 <= gray_next;
    end
  end

  // Reset clears in-flight Gray data so no stale value reappears after release.
  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= g1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Each decoded bit is the XOR of all Gray bits at and above it.
  always_comb begin
    bin_dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_dec[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  always_ff @(posedge clk2 or negedge reset) begin
    if (!reset) begin
      count_2 <= '0;
    end else begin
      count_2 <= bin_dec;
    end
  end

endmodule

// File: tb/tb_s2f_counter_core.sv
// Self-checking bench: default build plus a RATIO=4 / SYNC_STAGES=3 build,
// checked every cycle against an arithmetic model of the counter and its lag.
module tb_s2f_counter_core;

  logic       clk2;
  logic       reset;
  logic [3:0] c1_a, c2_a;
  logic [3:0] c1_b, c2_b;

  int errors   = 0;
  int n_checks = 0;
  int rel      = 0;
  int prev_rel = -1;
  logic [3:0] prev_c2_a, prev_c2_b, prev_g1_a;

  s2f_counter_core dut_a (
    .clk2    (clk2),
    .reset   (reset),
    .count_1 (c1_a),
    .count_2 (c2_a)
  );

  s2f_counter_core #(.WIDTH(4), .RATIO(4), .SYNC_STAGES(3)) dut_b (
    .clk2    (clk2),
    .reset   (reset),
    .count_1 (c1_b),
    .count_2 (c2_b)
  );

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // Edges seen with reset released; the model is a pure function of this.
  always @(posedge clk2 or negedge reset) begin
    if (!reset) rel <= 0;
    else        rel <= rel + 1;
  end

  function automatic int exp_c1(input int r, input int ratio);
    return (r / ratio) % 16;
  endfunction

  function automatic int exp_c2(input int r, input int ratio, input int stages);
    if (r < stages + 2) return 0;
    return ((r - stages - 2) / ratio) % 16;
  endfunction

  function automatic int popcount4(input logic [3:0] v);
    return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at rel=%0d: got %0h, expected %0h", name, rel, actual, expected);
    end
  endtask

  always @(negedge clk2) begin
    check_output("a.count_1", 32'(c1_a), 32'(exp_c1(rel, 2)));
    check_output("a.count_2", 32'(c2_a), 32'(exp_c2(rel, 2, 2)));
    check_output("b.count_1", 32'(c1_b), 32'(exp_c1(rel, 4)));
    check_output("b.count_2", 32'(c2_b), 32'(exp_c2(rel, 4, 3)));
    if (rel == prev_rel + 1) begin
      check_output("a.gray_step", 32'(popcount4(dut_a.g1 ^ prev_g1_a) <= 1), 32'd1);
      check_output("a.count_2_step",
                   32'((c2_a == prev_c2_a) || (c2_a == prev_c2_a + 4'd1)), 32'd1);
      check_output("b.count_2_step",
                   32'((c2_b == prev_c2_b) || (c2_b == prev_c2_b + 4'd1)), 32'd1);
    end
    prev_rel  = rel;
    prev_c2_a = c2_a;
    prev_c2_b = c2_b;
    prev_g1_a = dut_a.g1;
  end

  task automatic wait_rel(input int n);
    for (int k = 0; k < 200 && rel != n; k++) @(negedge clk2);
    if (rel != n) begin
      errors++;
      n_checks++;
      $display("[TB] FAIL wait_rel: reached %0d, expected %0d", rel, n);
    end
  endtask

  task automatic apply_stimulus(input int hold_cycles);
    reset = 1'b0;
    repeat (hold_cycles) @(negedge clk2);
    check_output("reset.count_1", 32'(c1_a), 32'd0);
    check_output("reset.count_2", 32'(c2_a), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    apply_stimulus(2);

    // Hand-computed anchors for the first run after release.
    wait_rel(2);  check_output("lit.a.c1@2",  32'(c1_a), 32'd1);
    wait_rel(4);  check_output("lit.b.c1@4",  32'(c1_b), 32'd1);
    wait_rel(6);  check_output("lit.a.c2@6",  32'(c2_a), 32'd1);
    wait_rel(9);  check_output("lit.b.c2@9",  32'(c2_b), 32'd1);
    wait_rel(31); check_output("lit.a.c1@31", 32'(c1_a), 32'd15);
    wait_rel(32); check_output("lit.a.c1@32", 32'(c1_a), 32'd0);
    wait_rel(35); check_output("lit.a.c2@35", 32'(c2_a), 32'd15);
    wait_rel(36); check_output("lit.a.c2@36", 32'(c2_a), 32'd0);
    wait_rel(40);

    apply_stimulus(2);
    wait_rel(14);
    check_output("lit.a.c1@14", 32'(c1_a), 32'd7);
    #2 reset = 1'b0;
    #1;
    check_output("async.count_1", 32'(c1_a), 32'd0);
    check_output("async.count_2", 32'(c2_a), 32'd0);
    check_output("async.b.count_1", 32'(c1_b), 32'd0);
    @(negedge clk2);
    apply_stimulus(2);
    wait_rel(2);  check_output("restart.c1@2", 32'(c1_a), 32'd1);
    wait_rel(6);  check_output("restart.c2@6", 32'(c2_a), 32'd1);
    wait_rel(20);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
